// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, FSM encoding and small helpers shared by
// the interrupt controller files.
package irq_ctrl_pkg;

  // Word offsets inside the 16-byte register window.
  localparam logic [3:0] IRQ_OFF_MASK = 4'h0;
  localparam logic [3:0] IRQ_OFF_PEND = 4'h4;
  localparam logic [3:0] IRQ_OFF_MODE = 4'h8;
  localparam logic [3:0] IRQ_OFF_CUR  = 4'hC;

  // Controller states: waiting, requesting the CPU, handler running.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } irq_state_e;

  // Round-robin start position after serving source id, wrapping at n_src.
  function automatic logic [2:0] next_rr_ptr(input logic [2:0] id, input int n_src);
    if (int'(id) >= n_src - 1) begin
      return 3'd0;
    end
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bridge register bus plus the CPU interrupt handshake.
// master = bridge/CPU side, slave = interrupt controller.
interface irq_ctrl_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack;

  modport master (
    output addr, we, wdata, int_ack,
    input  rdata, int_req, int_id
  );

  modport slave (
    input  addr, we, wdata, int_ack,
    output rdata, int_req, int_id
  );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational rotating priority encoder. Searches req
// upward starting at index start (wrapping) and returns the first hit.
// With start fixed at 0 it degenerates to lowest-index-wins.
module irq_prio_enc #(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] req,
  input  logic [2:0]       start,
  output logic             valid,
  output logic [2:0]       idx
);

  logic [N_SRC-1:0] w_rot;
  logic [2:0]       w_off;
  logic [3:0]       w_sum;

  // Rotate req so that bit 0 of w_rot corresponds to source 'start'.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
    logic [3:0] w_j;
    logic [2:0] w_k;
    assign w_j = 4'(gi) + {1'b0, start};
    assign w_k = 3'((w_j >= 4'(N_SRC)) ? (w_j - 4'(N_SRC)) : w_j);
    assign w_rot[gi] = req[w_k];
  end

  assign valid = |req;

  // Lowest set bit of the rotated vector is the first requester at/after start.
  always_comb begin
    w_off = 3'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 3'(k);
      end
    end
  end

  assign w_sum = {1'b0, start} + {1'b0, w_off};
  assign idx   = (w_sum >= 4'(N_SRC)) ? 3'(w_sum - 4'(N_SRC)) : w_sum[2:0];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped external interrupt controller.
// Latches device lines into PEND (edge or level per MODE), masks them,
// picks a winner, requests the CPU, and waits for ack then EOI.
// Optional feature macro: IRQ_RR_PRIO_EN (round-robin arbitration, with
// the rotation pointer readable in CUR[7:4]); default is fixed priority.
module irq_ctrl #(
  parameter int          N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h7f20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus
);
  import irq_ctrl_pkg::*;

  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_src_qq;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] w_pend_next;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_id_sel;

  irq_state_e r_state;
  irq_state_e w_state_next;
  logic       r_int_req;
  logic       w_int_req_next;
  logic [2:0] r_int_id;
  logic [2:0] w_int_id_next;

  logic       w_in_win;
  logic [3:0] w_off;
  logic       w_wr_mask;
  logic       w_wr_pend;
  logic       w_wr_mode;
  logic       w_wr_cur;
  logic       w_ack;
  logic       w_cur_active;
  logic       w_win_valid;
  logic [2:0] w_win_idx;
  logic [2:0] w_start;
  logic [3:0] w_ptr_field;
  logic [31:0] w_rdata;

  // Address decode: the window is 16-byte aligned, offsets are exact words.
  assign w_in_win  = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = bus.addr[3:0];
  assign w_wr_mask = bus.we & w_in_win & (w_off == IRQ_OFF_MASK);
  assign w_wr_pend = bus.we & w_in_win & (w_off == IRQ_OFF_PEND);
  assign w_wr_mode = bus.we & w_in_win & (w_off == IRQ_OFF_MODE);
  assign w_wr_cur  = bus.we & w_in_win & (w_off == IRQ_OFF_CUR);

  // Acks only count while a request is actually outstanding.
  assign w_ack = bus.int_ack & (r_state == S_REQ);

`ifdef IRQ_RR_PRIO_EN
  logic [2:0] r_rr_ptr;

  // Move the search start just past each acknowledged source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 3'd0;
    end else if (w_ack) begin
      r_rr_ptr <= next_rr_ptr(r_int_id, N_SRC);
    end
  end

  assign w_start     = r_rr_ptr;
  assign w_ptr_field = {1'b0, r_rr_ptr};
`else
  assign w_start     = 3'd0;
  assign w_ptr_field = 4'd0;
`endif

  assign w_edge   = r_src_q & ~r_src_qq;
  assign w_active = r_pend & r_mask;

  // Per-source pending logic: edge bits latch (set beats clear), level bits follow src_q.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
    logic w_clr;
    assign w_id_sel[gi]    = (r_int_id == 3'(gi));
    assign w_clr           = (w_ack & w_id_sel[gi]) | (w_wr_pend & bus.wdata[gi]);
    assign w_pend_next[gi] = r_mode[gi] ? (w_edge[gi] | (r_pend[gi] & ~w_clr))
                                        : r_src_q[gi];
  end

  // The current request is still justified only while its source stays pending and enabled.
  assign w_cur_active = |(w_active & w_id_sel);

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req   (w_active),
    .start (w_start),
    .valid (w_win_valid),
    .idx   (w_win_idx)
  );

  // Sample device lines, keep edge history, hold control and pending registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_q  <= '0;
      r_src_qq <= '0;
      r_mask   <= '0;
      r_mode   <= '0;
      r_pend   <= '0;
    end else begin
      r_src_q  <= src;
      r_src_qq <= r_src_q;
      r_pend   <= w_pend_next;
      if (w_wr_mask) begin
        r_mask <= bus.wdata[N_SRC-1:0];
      end
      if (w_wr_mode) begin
        r_mode <= bus.wdata[N_SRC-1:0];
      end
    end
  end

  // FSM state plus the registered request/id outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_int_req <= 1'b0;
      r_int_id  <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_int_req <= w_int_req_next;
      r_int_id  <= w_int_id_next;
    end
  end

  // Next-state logic: request on any enabled pending source, then ack, then EOI.
  always_comb begin
    w_state_next   = r_state;
    w_int_req_next = r_int_req;
    w_int_id_next  = r_int_id;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_next   = S_REQ;
          w_int_req_next = 1'b1;
          w_int_id_next  = w_win_idx;
        end
      end
      S_REQ: begin
        if (bus.int_ack) begin
          w_state_next   = S_SVC;
          w_int_req_next = 1'b0;
        end else if (!w_cur_active) begin
          w_state_next   = S_IDLE;
          w_int_req_next = 1'b0;
          w_int_id_next  = 3'd0;
        end
      end
      S_SVC: begin
        if (w_wr_cur) begin
          w_state_next  = S_IDLE;
          w_int_id_next = 3'd0;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_int_req_next = 1'b0;
        w_int_id_next  = 3'd0;
      end
    endcase
  end

  // Register read mux; CUR packs in_svc at bit 3 above the 3-bit id.
  always_comb begin
    w_rdata = 32'd0;
    if (w_in_win) begin
      case (w_off)
        IRQ_OFF_MASK: w_rdata = 32'(r_mask);
        IRQ_OFF_PEND: w_rdata = 32'(r_pend);
        IRQ_OFF_MODE: w_rdata = 32'(r_mode);
        IRQ_OFF_CUR:  w_rdata = {24'd0, w_ptr_field, (r_state == S_SVC), r_int_id};
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.rdata   = w_rdata;
  assign bus.int_req = r_int_req;
  assign bus.int_id  = r_int_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed bench for irq_ctrl with a cycle-level reference
// model (pending bits + "who is requesting / who is in service") checked
// against the DUT on every falling edge, plus literal spot checks.
module tb_irq_ctrl;
  localparam int          N    = 6;
  localparam logic [31:0] BASE = 32'h7f20;
  localparam logic [3:0]  O_MASK = 4'h0;
  localparam logic [3:0]  O_PEND = 4'h4;
  localparam logic [3:0]  O_MODE = 4'h8;
  localparam logic [3:0]  O_CUR  = 4'hC;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] src   = '0;

  irq_ctrl_if bus();

  irq_ctrl #(
    .N_SRC     (N),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  bit [N-1:0] m_srcq  = '0;
  bit [N-1:0] m_srcqq = '0;
  bit [N-1:0] m_mask  = '0;
  bit [N-1:0] m_mode  = '0;
  bit [N-1:0] m_pend  = '0;
  int         m_req   = -1;  // source currently requesting the CPU, -1 none
  int         m_svc   = -1;  // source whose handler is running, -1 none
  int         m_ptr   = 0;

  function automatic int pick(input bit [N-1:0] act, input int start);
    logic [2:0] b;
    for (int k = 0; k < N; k++) begin
      b = 3'((start + k) % N);
      if (act[b]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    int          id;
    r = 32'd0;
    if ((a >> 4) != (BASE >> 4)) return 32'd0;
    case (a[3:0])
      4'h0: r = 32'(m_mask);
      4'h4: r = 32'(m_pend);
      4'h8: r = 32'(m_mode);
      4'hC: begin
        id = (m_req >= 0) ? m_req : ((m_svc >= 0) ? m_svc : 0);
        r  = 32'(id) + ((m_svc >= 0) ? 32'd8 : 32'd0);
`ifdef IRQ_RR_PRIO_EN
        r  = r + 32'(m_ptr) * 32'd16;
`endif
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_srcq = '0; m_srcqq = '0; m_mask = '0; m_mode = '0; m_pend = '0;
      m_req = -1; m_svc = -1; m_ptr = 0;
    end else begin : upd
      bit [N-1:0] np;
      bit         wr_hit, ack_ok, eoi_ok, w1c;
      int         nreq, nsvc, nptr;
      logic [2:0] b, rq;
      wr_hit = bus.we && ((bus.addr >> 4) == (BASE >> 4));
      ack_ok = bus.int_ack && (m_req >= 0);
      eoi_ok = wr_hit && (bus.addr[3:0] == O_CUR) && (m_svc >= 0);
      for (int i = 0; i < N; i++) begin
        b   = 3'(i);
        w1c = wr_hit && (bus.addr[3:0] == O_PEND) && bus.wdata[b];
        if (!m_mode[b])                      np[b] = m_srcq[b];
        else if (m_srcq[b] && !m_srcqq[b])   np[b] = 1'b1;
        else if (w1c || (ack_ok && m_req == i)) np[b] = 1'b0;
        else                                 np[b] = m_pend[b];
      end
      nreq = m_req; nsvc = m_svc; nptr = m_ptr;
      if (m_req >= 0) begin
        rq = 3'(m_req);
        if (ack_ok) begin
          nsvc = m_req; nreq = -1; nptr = (m_req + 1) % N;
        end else if (!(m_pend[rq] && m_mask[rq])) begin
          nreq = -1;
        end
      end else if (m_svc >= 0) begin
        if (eoi_ok) nsvc = -1;
      end else begin
`ifdef IRQ_RR_PRIO_EN
        nreq = pick(m_pend & m_mask, m_ptr);
`else
        nreq = pick(m_pend & m_mask, 0);
`endif
      end
      if (wr_hit && bus.addr[3:0] == O_MASK) m_mask = bus.wdata[N-1:0];
      if (wr_hit && bus.addr[3:0] == O_MODE) m_mode = bus.wdata[N-1:0];
      m_pend = np; m_req = nreq; m_svc = nsvc; m_ptr = nptr;
      m_srcqq = m_srcq; m_srcq = src;
    end
  end

  // Cycle compare against the model on the inactive edge.
  always @(negedge clk) begin
    logic       exp_req;
    logic [31:0] exp_rd;
    int         exp_id;
    exp_req = (m_req >= 0);
    exp_id  = (m_req >= 0) ? m_req : m_svc;
    exp_rd  = exp_read(bus.addr);
    vectors++;
    if (bus.int_req !== exp_req) begin
      miscompares++;
      $display("FAIL cyc int_req @%0t: got %0b expected %0b", $time, bus.int_req, exp_req);
    end
    if ((m_req >= 0 || m_svc >= 0) && bus.int_id !== 3'(exp_id)) begin
      miscompares++;
      $display("FAIL cyc int_id @%0t: got %0d expected %0d", $time, bus.int_id, exp_id);
    end
    if (bus.rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL cyc rdata @%0t addr 0x%0h: got 0x%0h expected 0x%0h", $time, bus.addr, bus.rdata, exp_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    bus.addr  = BASE + 32'(off);
    bus.wdata = d;
    bus.we    = 1'b1;
    $display("wr  off=0x%0h data=0x%0h", off, d);
    tick();
    bus.we = 1'b0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    $display("ack id=%0d rr=%0d", bus.int_id, m_ptr);
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] msk,
                        input logic [31:0] exp);
    bus.addr = a;
    #1;
    $display("rd  0x%0h -> 0x%0h", a, bus.rdata);
    chk(name, bus.rdata & msk, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.addr = BASE; bus.we = 1'b0; bus.wdata = 32'd0; bus.int_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    rd_chk("reset MASK", BASE + 32'(O_MASK), 32'hFFFF_FFFF, 32'd0);
    chk("reset int_req", 32'(bus.int_req), 32'd0);

    // 1. reset while requesting
    wr(O_MASK, 32'h01);
    src = 6'b000001;
    repeat (3) tick();
    chk("t1 int_req up", 32'(bus.int_req), 32'd1);
    reset = 1'b1;
    #1;
    $display("reset asserted mid-request");
    chk("t1 int_req async clear", 32'(bus.int_req), 32'd0);
    rd_chk("t1 MASK", BASE + 32'(O_MASK), 32'hFFFF_FFFF, 32'd0);
    rd_chk("t1 PEND", BASE + 32'(O_PEND), 32'hFFFF_FFFF, 32'd0);
    rd_chk("t1 MODE", BASE + 32'(O_MODE), 32'hFFFF_FFFF, 32'd0);
    rd_chk("t1 CUR",  BASE + 32'(O_CUR),  32'hFFFF_FFFF, 32'd0);
    src = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 2. single edge source, ack, EOI
    wr(O_MASK, 32'h3F);
    wr(O_MODE, 32'h3F);
    src = 6'b000100;
    tick(); tick();
    chk("t2 no req after 2 edges", 32'(bus.int_req), 32'd0);
    tick();
    chk("t2 int_req", 32'(bus.int_req), 32'd1);
    chk("t2 int_id", 32'(bus.int_id), 32'd2);
    ack();
    chk("t2 req after ack", 32'(bus.int_req), 32'd0);
    rd_chk("t2 PEND", BASE + 32'(O_PEND), 32'hFFFF_FFFF, 32'd0);
    rd_chk("t2 CUR svc", BASE + 32'(O_CUR), 32'h0F, 32'h0A);
`ifdef IRQ_RR_PRIO_EN
    rd_chk("t2 rr_ptr", BASE + 32'(O_CUR), 32'hF0, 32'h30);
`endif
    wr(O_CUR, 32'd0);
    rd_chk("t2 CUR eoi", BASE + 32'(O_CUR), 32'h0F, 32'h00);
    src = '0;
    tick();

    // 3. two simultaneous edges
    src = 6'b100010;
    repeat (3) tick();
    chk("t3 int_req 1st", 32'(bus.int_req), 32'd1);
`ifdef IRQ_RR_PRIO_EN
    chk("t3 id 1st", 32'(bus.int_id), 32'd5);
`else
    chk("t3 id 1st", 32'(bus.int_id), 32'd1);
`endif
    ack();
    wr(O_CUR, 32'd0);
    tick();
    chk("t3 int_req 2nd", 32'(bus.int_req), 32'd1);
`ifdef IRQ_RR_PRIO_EN
    chk("t3 id 2nd", 32'(bus.int_id), 32'd1);
`else
    chk("t3 id 2nd", 32'(bus.int_id), 32'd5);
`endif
    ack();
    wr(O_CUR, 32'd0);
    src = '0;
    tick();
`ifdef IRQ_RR_PRIO_EN
    wr(O_MODE, 32'h3C);
    src = 6'b000011;
    repeat (3) tick();
    for (int r = 0; r < 4; r++) begin
      chk("t3 rr order", 32'(bus.int_id), 32'(r % 2));
      ack();
      wr(O_CUR, 32'd0);
      tick();
    end
    src = '0;
    repeat (3) tick();
    wr(O_MODE, 32'h3F);
`endif

    // 4. level source withdrawn before ack
    wr(O_MASK, 32'h01);
    wr(O_MODE, 32'h00);
    src = 6'b000001;
    repeat (3) tick();
    chk("t4 int_req", 32'(bus.int_req), 32'd1);
    chk("t4 int_id", 32'(bus.int_id), 32'd0);
    src = '0;
    tick(); tick();
    chk("t4 still req", 32'(bus.int_req), 32'd1);
    tick();
    chk("t4 withdrawn", 32'(bus.int_req), 32'd0);
    rd_chk("t4 CUR idle", BASE + 32'(O_CUR), 32'h0F, 32'h00);

    // 5. edge arriving during service waits for EOI
    wr(O_MASK, 32'h3F);
    wr(O_MODE, 32'h3F);
    src = 6'b000001;
    repeat (3) tick();
    chk("t5 id0 req", 32'(bus.int_id), 32'd0);
    ack();
    src = 6'b001001;
    tick();
    src = 6'b000001;
    tick(); tick();
    rd_chk("t5 PEND", BASE + 32'(O_PEND), 32'hFFFF_FFFF, 32'h08);
    chk("t5 no req in svc", 32'(bus.int_req), 32'd0);
    wr(O_CUR, 32'd0);
    chk("t5 no req at eoi", 32'(bus.int_req), 32'd0);
    tick();
    chk("t5 req after eoi", 32'(bus.int_req), 32'd1);
    chk("t5 id3", 32'(bus.int_id), 32'd3);
    ack();
    wr(O_CUR, 32'd0);
    src = '0;
    tick();

    // 6. W1C collides with a new edge: set wins
    wr(O_MASK, 32'h00);
    src = 6'b001000;
    tick();
    wr(O_PEND, 32'h08);
    rd_chk("t6 set beats clr", BASE + 32'(O_PEND), 32'hFFFF_FFFF, 32'h08);
    wr(O_PEND, 32'h08);
    rd_chk("t6 w1c", BASE + 32'(O_PEND), 32'hFFFF_FFFF, 32'h00);

    // boundaries: write width, out-of-window and unaligned reads, stray ack/EOI
    wr(O_MASK, 32'hFFFF_FFFF);
    rd_chk("mask width", BASE + 32'(O_MASK), 32'hFFFF_FFFF, 32'h3F);
    rd_chk("beyond window", BASE + 32'h10, 32'hFFFF_FFFF, 32'd0);
    rd_chk("below window", 32'd0, 32'hFFFF_FFFF, 32'd0);
    rd_chk("unaligned", BASE + 32'h2, 32'hFFFF_FFFF, 32'd0);
    wr(O_CUR, 32'd0);
    ack();
    chk("stray ack", 32'(bus.int_req), 32'd0);
    src = '0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
